// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, states, class bits.
package alu_ctrl_fsm_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 3;

  // Opcode map, shared with the combinational ALU
  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_LD   = 4'd6;
  localparam logic [OP_W-1:0] OP_ST   = 4'd7;
  localparam logic [OP_W-1:0] OP_INC  = 4'd8;
  localparam logic [OP_W-1:0] OP_DEC  = 4'd9;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd10;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd11;
  localparam logic [OP_W-1:0] OP_NOP  = 4'd12;
  localparam logic [OP_W-1:0] OP_JMP  = 4'd13;
  localparam logic [OP_W-1:0] OP_JZ   = 4'd14;
  localparam logic [OP_W-1:0] OP_HALT = 4'd15;

  // Sequencer states
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd4;

  // Per-opcode class bits produced by the decoder
  typedef struct packed {
    logic uses_carry;
    logic writes_acc;
    logic writes_mem;
    logic reads_mem;
    logic is_branch;
  } op_class_t;

  // Opcodes that occupy an ALU EXEC cycle (includes LD/ST)
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode classifier for the ALU sequencer.
module alu_ctrl_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output op_class_t       cls
);

  // Derive class bits from the opcode
  always_comb begin
    cls            = '0;
    cls.uses_carry = (opcode == OP_ADD) || (opcode == OP_SUB);
    cls.writes_mem = (opcode == OP_ST);
    cls.reads_mem  = (opcode == OP_LD);
    cls.writes_acc = is_alu_op(opcode) && (opcode != OP_ST);
    cls.is_branch  = (opcode == OP_JMP) || (opcode == OP_JZ);
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Instruction sequencer driving a combinational ALU: fetch/decode/mem/exec FSM,
// program counter, carry/zero flags and datapath strobes.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [ADDR_W+3:0]    instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [ADDR_W-1:0]    pc,
  output logic                 alu_ce,
  output logic [OP_W-1:0]      alu_op,
  output logic                 alu_carry_in,
  input  logic                 alu_carry_out,
  input  logic [SIZE-1:0]      alu_result,
  output logic                 acc_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 halted
);

  localparam int unsigned INSTR_W = OP_W + ADDR_W;

  logic [STATE_W-1:0] state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  operand;
  logic [ADDR_W-1:0]  pc_inc;
  op_class_t          cls;

  assign op      = ir_q[INSTR_W-1:ADDR_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);

  alu_ctrl_decode u_decode (
    .opcode (op),
    .cls    (cls)
  );

  // State, IR, pc and flag registers; reset abandons any in-flight instruction
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state, pc and flag update
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.is_branch) begin
          // JZ samples the flag registered before this cycle
          pc_d    = ((op == OP_JMP) || zero_q) ? operand : pc_inc;
          state_d = ST_FETCH;
        end else if (op == OP_NOP) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (cls.reads_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls.writes_acc) begin
          zero_d = (alu_result == '0);
        end
        if (cls.uses_carry) begin
          carry_d = alu_carry_out;
        end
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Outputs are pure decodes of registered state and IR
  assign instr_ready  = RST_N && (state_q == ST_FETCH);
  assign alu_ce       = (state_q == ST_EXEC);
  assign alu_op       = op;
  assign alu_carry_in = (state_q == ST_EXEC) && cls.uses_carry && carry_q;
  assign acc_we       = (state_q == ST_EXEC) && cls.writes_acc;
  assign mem_we       = (state_q == ST_EXEC) && cls.writes_mem;
  assign mem_re       = (state_q == ST_DECODE) && cls.reads_mem;
  assign mem_addr     = operand;
  assign pc           = pc_q;
  assign carry_flag   = carry_q;
  assign zero_flag    = zero_q;
  assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for the ALU instruction sequencer.
module tb_alu_ctrl_fsm;

  logic       CLK;
  logic       RST_N;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] pc;
  logic       alu_ce;
  logic [3:0] alu_op;
  logic       alu_carry_in;
  logic       alu_carry_out;
  logic [7:0] alu_result;
  logic       acc_we;
  logic [3:0] mem_addr;
  logic       mem_re;
  logic       mem_we;
  logic       carry_flag;
  logic       zero_flag;
  logic       halted;

  int checks = 0;
  int errors = 0;

  alu_ctrl_fsm #(.SIZE(8), .ADDR_W(4)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .alu_ce        (alu_ce),
    .alu_op        (alu_op),
    .alu_carry_in  (alu_carry_in),
    .alu_carry_out (alu_carry_out),
    .alu_result    (alu_result),
    .acc_we        (acc_we),
    .mem_addr      (mem_addr),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .carry_flag    (carry_flag),
    .zero_flag     (zero_flag),
    .halted        (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for ready, present one word for exactly one accept edge
  task automatic issue(input logic [3:0] opc, input logic [3:0] opnd);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!instr_ready) begin
      errors++;
      $display("FAIL issue_ready_timeout: instr_ready=%0b required 1", instr_ready);
    end
    instr       = {opc, opnd};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0h need 0", pc); end
    checks++;
    if ({carry_flag, zero_flag} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b need 00", {carry_flag, zero_flag});
    end
    checks++;
    if ({alu_ce, acc_we, mem_re, mem_we, halted, instr_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b need 000000",
                         {alu_ce, acc_we, mem_re, mem_we, halted, instr_ready});
    end
    checks++;
    if (alu_op !== 4'd0) begin errors++; $display("FAIL reset_alu_op: got %0h need 0", alu_op); end
    RST_N = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b need 1", instr_ready);
    end
  endtask

  task automatic test_add;
    alu_result    = 8'h00;
    alu_carry_out = 1'b1;
    issue(4'd0, 4'd0);
    checks++;
    if ({instr_ready, alu_ce} !== 2'b00) begin
      errors++; $display("FAIL add_decode: ready/ce got %b need 00", {instr_ready, alu_ce});
    end
    tick();
    checks++;
    if ({alu_ce, alu_op, alu_carry_in, acc_we} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_exec: ce/op/cin/we got %b need 1_0000_0_1",
                         {alu_ce, alu_op, alu_carry_in, acc_we});
    end
    tick();
    checks++;
    if ({zero_flag, carry_flag} !== 2'b11) begin
      errors++; $display("FAIL add_flags: z/c got %b need 11", {zero_flag, carry_flag});
    end
    checks++;
    if (pc !== 4'd1) begin errors++; $display("FAIL add_pc: got %0h need 1", pc); end
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b need 1", instr_ready); end
    // second ADD consumes the stored carry
    issue(4'd0, 4'd0);
    tick();
    checks++;
    if (alu_carry_in !== 1'b1) begin
      errors++; $display("FAIL add2_carry_in: got %b need 1", alu_carry_in);
    end
    tick();
    // AND: clears zero, must not touch carry
    alu_result    = 8'h0F;
    alu_carry_out = 1'b0;
    issue(4'd2, 4'd0);
    tick();
    checks++;
    if ({alu_carry_in, alu_op} !== {1'b0, 4'd2}) begin
      errors++; $display("FAIL and_exec: cin/op got %b need 0_0010", {alu_carry_in, alu_op});
    end
    tick();
    checks++;
    if ({zero_flag, carry_flag} !== 2'b01) begin
      errors++; $display("FAIL and_flags: z/c got %b need 01", {zero_flag, carry_flag});
    end
    checks++;
    if (pc !== 4'd3) begin errors++; $display("FAIL and_pc: got %0h need 3", pc); end
  endtask

  task automatic test_ld;
    int lat;
    alu_result = 8'h55;
    issue(4'd6, 4'h9);
    lat = 1;
    checks++;
    if ({mem_re, mem_addr, alu_ce} !== {1'b1, 4'h9, 1'b0}) begin
      errors++; $display("FAIL ld_decode: re/addr/ce got %b need 1_1001_0", {mem_re, mem_addr, alu_ce});
    end
    tick(); lat++;
    checks++;
    if ({mem_re, mem_addr, alu_ce, instr_ready} !== {1'b0, 4'h9, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ld_mem: re/addr/ce/rdy got %b need 0_1001_0_0",
                         {mem_re, mem_addr, alu_ce, instr_ready});
    end
    tick(); lat++;
    checks++;
    if ({alu_ce, acc_we, alu_op, mem_we} !== {1'b1, 1'b1, 4'd6, 1'b0}) begin
      errors++; $display("FAIL ld_exec: ce/we/op/mwe got %b need 1_1_0110_0",
                         {alu_ce, acc_we, alu_op, mem_we});
    end
    while (!instr_ready && lat < 10) begin
      tick(); lat++;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL ld_latency: got %0d need 4", lat); end
    checks++;
    if ({pc, zero_flag, carry_flag} !== {4'd4, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ld_after: pc/z/c got %b need 0100_0_1", {pc, zero_flag, carry_flag});
    end
  endtask

  task automatic test_st;
    alu_result    = 8'h00;
    alu_carry_out = 1'b0;
    issue(4'd7, 4'h3);
    checks++;
    if (mem_re !== 1'b0) begin errors++; $display("FAIL st_decode_re: got %b need 0", mem_re); end
    tick();
    checks++;
    if ({mem_we, mem_addr, acc_we, alu_ce, alu_op} !== {1'b1, 4'h3, 1'b0, 1'b1, 4'd7}) begin
      errors++; $display("FAIL st_exec: mwe/addr/awe/ce/op got %b need 1_0011_0_1_0111",
                         {mem_we, mem_addr, acc_we, alu_ce, alu_op});
    end
    tick();
    checks++;
    if ({zero_flag, carry_flag, pc} !== {1'b0, 1'b1, 4'd5}) begin
      errors++; $display("FAIL st_after: z/c/pc got %b need 0_1_0101", {zero_flag, carry_flag, pc});
    end
  endtask

  task automatic test_branch;
    // XOR with zero result sets zero_flag
    alu_result = 8'h00;
    issue(4'd4, 4'd0);
    repeat (2) tick();
    checks++;
    if ({zero_flag, carry_flag, pc} !== {1'b1, 1'b1, 4'd6}) begin
      errors++; $display("FAIL xor_after: z/c/pc got %b need 1_1_0110", {zero_flag, carry_flag, pc});
    end
    issue(4'd14, 4'hA);
    checks++;
    if (alu_ce !== 1'b0) begin errors++; $display("FAIL jz_taken_ce: got %b need 0", alu_ce); end
    tick();
    checks++;
    if ({pc, instr_ready} !== {4'hA, 1'b1}) begin
      errors++; $display("FAIL jz_taken: pc/rdy got %b need 1010_1", {pc, instr_ready});
    end
    alu_result = 8'h01;
    issue(4'd3, 4'd0);
    repeat (2) tick();
    checks++;
    if ({zero_flag, pc} !== {1'b0, 4'd11}) begin
      errors++; $display("FAIL or_after: z/pc got %b need 0_1011", {zero_flag, pc});
    end
    issue(4'd13, 4'hF);
    checks++;
    if (alu_ce !== 1'b0) begin errors++; $display("FAIL jmp_ce: got %b need 0", alu_ce); end
    tick();
    checks++;
    if (pc !== 4'hF) begin errors++; $display("FAIL jmp_f_pc: got %0h need f", pc); end
    issue(4'd14, 4'h3);
    tick();
    checks++;
    if (pc !== 4'h0) begin errors++; $display("FAIL jz_wrap_pc: got %0h need 0", pc); end
    issue(4'd13, 4'h5);
    tick();
    checks++;
    if (pc !== 4'h5) begin errors++; $display("FAIL jmp_5_pc: got %0h need 5", pc); end
    issue(4'd12, 4'h9);
    checks++;
    if ({alu_ce, mem_re} !== 2'b00) begin
      errors++; $display("FAIL nop_decode: ce/re got %b need 00", {alu_ce, mem_re});
    end
    tick();
    checks++;
    if ({pc, instr_ready} !== {4'h6, 1'b1}) begin
      errors++; $display("FAIL nop_after: pc/rdy got %b need 0110_1", {pc, instr_ready});
    end
  endtask

  task automatic test_halt;
    issue(4'd15, 4'd0);
    tick();
    instr       = 8'h00;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({halted, instr_ready, alu_ce, acc_we, mem_we, mem_re, pc} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6}) begin
        errors++; $display("FAIL halt_cycle%0d: h/rdy/ce/awe/mwe/re/pc got %b need 1_0_0_0_0_0_0110",
                           i, {halted, instr_ready, alu_ce, acc_we, mem_we, mem_re, pc});
      end
      tick();
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    test_reset();
    alu_result    = 8'h00;
    alu_carry_out = 1'b1;
    issue(4'd0, 4'd0);
    repeat (2) tick();
    checks++;
    if ({zero_flag, carry_flag, pc} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL pre_rst_state: z/c/pc got %b need 1_1_0001", {zero_flag, carry_flag, pc});
    end
    issue(4'd0, 4'd0);
    tick();
    checks++;
    if ({alu_ce, acc_we} !== 2'b11) begin
      errors++; $display("FAIL pre_rst_exec: ce/we got %b need 11", {alu_ce, acc_we});
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({alu_ce, acc_we, mem_we, mem_re, instr_ready, halted} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_strobes: got %b need 000000",
                         {alu_ce, acc_we, mem_we, mem_re, instr_ready, halted});
    end
    checks++;
    if ({pc, zero_flag, carry_flag} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_state: pc/z/c got %b need 0000_0_0", {pc, zero_flag, carry_flag});
    end
    tick();
    checks++;
    if (acc_we !== 1'b0) begin errors++; $display("FAIL rst_hold_acc_we: got %b need 0", acc_we); end
    RST_N = 1'b1;
    #1;
    checks++;
    if ({instr_ready, pc, zero_flag, carry_flag} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_release: rdy/pc/z/c got %b need 1_0000_0_0",
                         {instr_ready, pc, zero_flag, carry_flag});
    end
  endtask

  initial begin
    RST_N         = 1'b0;
    instr         = 8'h00;
    instr_valid   = 1'b0;
    alu_result    = 8'h00;
    alu_carry_out = 1'b0;
    test_reset();
    test_add();
    test_ld();
    test_st();
    test_branch();
    test_halt();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
